// File: rtl/gpmc_wb16_to_litex_wb32_bridge.sv
// rtl/gpmc_wb16_to_litex_wb32_bridge.sv - 16-bit halfword Wishbone slave to 32-bit LiteX classic Wishbone master
//
// Purpose:
//   Turns each 16-bit halfword access from gpmc_to_wishbone into a single 32-bit
//   word access on the LiteX SoC bus. The SDRAM window base is added to the address.
//   The halfword is steered onto the correct byte lanes. A bus timeout and error status
//   are also provided. Because of these, a hung or erroring SoC slave always returns a
//   completion to the GPMC side.
//
// Optional feature macro: READ_PREFETCH_EN
//   When defined, a one-entry cache keeps the upper halfword of the last even-halfword
//   read. A following odd-halfword read of the same word is answered without a bus access.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   s_adr/s_dat_w/s_dat_r 16-bit halfword-addressed slave port (from gpmc_to_wishbone)
//   s_cyc/s_stb/s_we      slave request; s_ack is a one-cycle completion pulse
//   m_adr/m_dat_w/m_dat_r 30-bit word-addressed, 32-bit data master port (to SoC)
//   m_sel/m_cyc/m_stb/m_we master byte lanes and request
//   m_cti/m_bte           tied to classic-cycle encodings
//   m_ack/m_err           SoC slave termination
//   err_clr               clears err_sticky and err_count
//   err_sticky/err_count  error/timeout status; the count saturates at 8'hFF

module gpmc_wb16_to_litex_wb32_bridge #(
    parameter int          S_ADDR_WIDTH   = 16,
    parameter logic [29:0] BASE_WORD_ADR  = 30'h10000000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [S_ADDR_WIDTH-1:0] s_adr,
    input  logic [15:0]             s_dat_w,
    output logic [15:0]             s_dat_r,
    input  logic                    s_cyc,
    input  logic                    s_stb,
    input  logic                    s_we,
    output logic                    s_ack,
    output logic [29:0]             m_adr,
    output logic [31:0]             m_dat_w,
    input  logic [31:0]             m_dat_r,
    output logic [3:0]              m_sel,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [2:0]              m_cti,
    output logic [1:0]              m_bte,
    input  logic                    m_ack,
    input  logic                    m_err,
    input  logic                    err_clr,
    output logic                    err_sticky,
    output logic [7:0]              err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tcnt;
    // Halfword select of the access in flight; it picks the read lane on m_ack.
    logic        r_hi;

    logic        w_req;
    logic [29:0] w_word_adr;
    logic        w_timeout;
    logic        w_err_evt;
    logic        w_pf_hit;

    assign m_cti = 3'b000;
    assign m_bte = 2'b00;

    assign w_req      = s_cyc & s_stb;
    // The address wraps modulo 2^30 through the natural 30-bit add.
    assign w_word_adr = BASE_WORD_ADR + 30'(s_adr[S_ADDR_WIDTH-1:1]);
    assign w_timeout  = (r_tcnt == 8'(TIMEOUT_CYCLES - 1)) & ~m_ack;
    // m_err outranks m_ack, so an ack+err cycle counts as an error.
    assign w_err_evt  = (r_state == ST_REQ) & (m_err | w_timeout);

`ifdef READ_PREFETCH_EN
    logic        r_pf_valid;
    logic [29:0] r_pf_adr;
    logic [15:0] r_pf_data;

    assign w_pf_hit = r_pf_valid & ~s_we & s_adr[0] & (r_pf_adr == w_word_adr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pf_valid <= 1'b0;
            r_pf_adr   <= 30'd0;
            r_pf_data  <= 16'd0;
        end else if (r_state == ST_IDLE && w_req && s_we) begin
            r_pf_valid <= 1'b0;
        end else if (w_err_evt) begin
            r_pf_valid <= 1'b0;
        end else if (r_state == ST_REQ && m_ack && !m_we && !r_hi) begin
            r_pf_valid <= 1'b1;
            r_pf_adr   <= m_adr;
            r_pf_data  <= m_dat_r[31:16];
        end
    end
`else
    assign w_pf_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tcnt  <= 8'd0;
            r_hi    <= 1'b0;
            s_dat_r <= 16'd0;
            s_ack   <= 1'b0;
            m_adr   <= 30'd0;
            m_dat_w <= 32'd0;
            m_sel   <= 4'd0;
            m_cyc   <= 1'b0;
            m_stb   <= 1'b0;
            m_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    s_ack <= 1'b0;
                    if (w_req) begin
                        if (w_pf_hit) begin
`ifdef READ_PREFETCH_EN
                            s_dat_r <= r_pf_data;
`endif
                            s_ack   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            m_adr   <= w_word_adr;
                            m_sel   <= s_adr[0] ? 4'b1100 : 4'b0011;
                            m_we    <= s_we;
                            m_dat_w <= {s_dat_w, s_dat_w};
                            m_cyc   <= 1'b1;
                            m_stb   <= 1'b1;
                            r_hi    <= s_adr[0];
                            r_tcnt  <= 8'd0;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (m_err || w_timeout) begin
                        s_dat_r <= ERR_DATA;
                        s_ack   <= 1'b1;
                        m_cyc   <= 1'b0;
                        m_stb   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (m_ack) begin
                        if (m_we)
                            s_dat_r <= 16'd0;
                        else
                            s_dat_r <= r_hi ? m_dat_r[31:16] : m_dat_r[15:0];
                        s_ack   <= 1'b1;
                        m_cyc   <= 1'b0;
                        m_stb   <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    s_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    s_ack   <= 1'b0;
                    m_cyc   <= 1'b0;
                    m_stb   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status: a new error in the same cycle as err_clr wins, so that error is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (w_err_evt)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;

            if (err_clr)
                err_count <= w_err_evt ? 8'd1 : 8'd0;
            else if (w_err_evt && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
